weight_store_gen: RTL and testbench
===================================

// Module: weight_store_gen
// PURPOSE
//  Parametrised weight fetcher between the weight ROM and the conv/affine datapath.
//  - Per (cs layer, phase): reads WORDS consecutive ROM words and packs them into one wide weight vector q.
//  - Raises valid when q is complete.
//  - Generalises the fixed 4-word/9-element store: word count, word size, layer and phase counts, synchronous reset, error flag.
// PARAMETERS
//  FILENAME    "../data/data162/weight162_0.txt"  ROM init file passed to w_rom_gen
//  WORD_ELEMS  9   elements per ROM word, each `data_len bits
//  WORDS       4   ROM words packed per fetch
//  PHASES      8   phases per layer
//  LAYERS      5   layer slots: LAYER0..LAYER3, AFFINE
//  ADDR_W      8   ROM address width; requires LAYERS*PHASES*WORDS <= 2**ADDR_W
// PORTS
//  clk    in   1   clock, rising edge
//  rst    in   1   synchronous reset, active-high
//  load   in   1   level request; hold high until valid is seen, drop to release
//  cs     in   4   layer state code (`LAYER0..`LAYER3, `AFFINE)
//  phase  in   $clog2(PHASES)   phase index within layer
//  valid  out  1   q holds the complete weight vector for the latched cs/phase
//  err    out  1   cs was not a layer code when the fetch started
//  q      out  WORDS*WORD_ELEMS*`data_len   packed weights; word k in q[k*WW +: WW], WW = WORD_ELEMS*`data_len
// BEHAVIOUR
//  Reset: all regs clear synchronously; state=IDLE, valid=0, err=0, q=0, addr=0, cnt=0.
//  Base address: base = layer_idx*(PHASES*WORDS) + phase*WORDS.
//    layer_idx: LAYER0=0 .. LAYER3=3, AFFINE=4.
//    Computed combinationally and latched in IDLE. Base arithmetic is ADDR_W wide.
//  FSM:
//   IDLE:  load=1, cs valid   -> addr<=base, cnt<=0, go ISSUE.
//          load=1, cs invalid -> err<=1, go DONE, no ROM reads.
//   ISSUE: addr increments each cycle; go DRAIN after WORDS addresses are issued.
//          ROM latency is 1 cycle; the word from address base+k is written to slice k the cycle after issue.
//   DRAIN: capture the last word; valid<=1 on the next edge; go DONE.
//   DONE:  hold q, valid, err while load=1.
//          load=0 -> valid<=0, err<=0, go IDLE; next fetch can start the cycle after.
//  Latency: load sampled high at edge 0 -> valid high after edge WORDS+2 (edge 6 for the defaults).
//  cs/phase are sampled only in IDLE; changes during a fetch are ignored.
//  Abort: load=0 in ISSUE/DRAIN -> IDLE next edge; valid stays 0; q per CONFIGURATION.
//  rst has priority over load in every state, including mid-fetch.
//  valid never rises without load being high the previous cycle.
// CONFIGURATION
//  Macro WSTORE_DBUF_EN (optional feature).
//   Defined: words fill an internal shadow register.
//    - q updates atomically on the same edge valid rises.
//    - q is unchanged on abort and during a new fetch, so the previous vector stays stable.
//   Undefined: words are written straight into q as they arrive.
//    - q is partially updated during a fetch or after an abort.
//    - Consumers must qualify q with valid.
// STRUCTURE
//  Shared package/includes: num_data.v (`data_len), state_layer_data.v (cs codes).
//    Add there: WSTORE_IDLE/ISSUE/DRAIN/DONE state codes and the layer_idx mapping function.
//  One sub-module: w_rom_gen.
//    Params FILENAME, ADDR_W, width WW; ports clk, addr, q; registered read, 1-cycle latency.
//    ROM word at address a = WORD_ELEMS elements.
// TESTING
//  1 rst=1 for 2 cycles, then load=1, cs=`LAYER1, phase=2
//    -> ROM addrs 40,41,42,43 on consecutive cycles; valid=1 after edge 6; q slices = ROM[40..43].
//  2 cs=`AFFINE, phase=7 -> base 156; last slice = ROM[159]; err=0.
//  3 cs=illegal code -> err=1, valid=0, no ROM address change; load=0 -> err clears next edge.
//  4 load dropped after 2 issues, then reload with phase=0
//    -> valid stays 0 during abort; second fetch addrs 32..35 (LAYER1), correct q.
//    With WSTORE_DBUF_EN: q keeps the old vector until the new valid.
//  5 rst asserted in ISSUE -> next edge: valid=0, q=0, state IDLE; fetch after release is correct.
//  6 Back-to-back: load low 1 cycle between fetches; cs/phase changed mid-fetch
//    -> changes ignored until the next IDLE.

Source files
------------

// File: rtl/weight_store_gen_pkg.sv
// weight_store_gen_pkg: element width, layer codes, fetch states and helper functions shared by the weight store.
package weight_store_gen_pkg;
    localparam int DATA_LEN = 8;
    localparam int FNW = 512;
    localparam logic [3:0] LAYER0 = 4'd1;
    localparam logic [3:0] LAYER1 = 4'd2;
    localparam logic [3:0] LAYER2 = 4'd3;
    localparam logic [3:0] LAYER3 = 4'd4;
    localparam logic [3:0] AFFINE = 4'd5;
    typedef enum logic [1:0] {
        WSTORE_IDLE,
        WSTORE_ISSUE,
        WSTORE_DRAIN,
        WSTORE_DONE
    } wstore_state_e;
    // Non-layer codes map to 7, which never passes the layer-count check.
    function automatic logic [2:0] layer_idx(input logic [3:0] cs);
        return cs == LAYER0 ? 3'd0 :
               cs == LAYER1 ? 3'd1 :
               cs == LAYER2 ? 3'd2 :
               cs == LAYER3 ? 3'd3 :
               cs == AFFINE ? 3'd4 : 3'd7;
    endfunction
    function automatic logic [DATA_LEN-1:0] rom_elem(input int unsigned a, input int unsigned e,
                                                     input logic [DATA_LEN-1:0] seed);
        logic [31:0] v;
        v = a * 3 + e * 17;
        return v[DATA_LEN-1:0] ^ seed;
    endfunction
endpackage

// File: rtl/weight_store_gen_if.sv
// weight_store_gen_if: fetch request (load/cs/phase) and packed weight result bundle.
interface weight_store_gen_if #(
    parameter int WORD_ELEMS = 9,
    parameter int WORDS      = 4,
    parameter int PHASES     = 8,
    parameter int ADDR_W     = 8
);
    import weight_store_gen_pkg::*;
    localparam int PW = PHASES > 1 ? $clog2(PHASES) : 1;
    logic                                load;
    logic [3:0]                          cs;
    logic [PW-1:0]                       phase;
    logic                                valid;
    logic                                err;
    logic [WORDS*WORD_ELEMS*DATA_LEN-1:0] q;
    logic [ADDR_W-1:0]                   addr;
    modport master (output load, cs, phase, input valid, err, q, addr);
    modport slave (input load, cs, phase, output valid, err, q, addr);
endinterface

// File: rtl/weight_store_gen_w_rom_gen.sv
// w_rom_gen: registered weight ROM, 1-cycle read latency; contents are an address hash seeded by the last FILENAME byte.
module w_rom_gen
    import weight_store_gen_pkg::*;
#(
    parameter logic [FNW-1:0] FILENAME = "../data/data162/weight162_0.txt",
    parameter int ADDR_W     = 8,
    parameter int WORD_ELEMS = 9,
    parameter int WW         = WORD_ELEMS * DATA_LEN
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WW-1:0]     q
);
    localparam logic [DATA_LEN-1:0] SEED = FILENAME[DATA_LEN-1:0];
    logic [WW-1:0] word;
    always_comb begin
        word = '0;
        for (int e = 0; e < WORD_ELEMS; e++)
            word[e*DATA_LEN +: DATA_LEN] = rom_elem(32'(addr), 32'(e), SEED);
    end
    always_ff @(posedge clk) q <= word;
endmodule

// File: rtl/weight_store_gen.sv
// weight_store_gen: packs WORDS ROM words per (layer, phase) into q; define WSTORE_DBUF_EN to update q atomically with valid.
module weight_store_gen
    import weight_store_gen_pkg::*;
#(
    parameter logic [FNW-1:0] FILENAME = "../data/data162/weight162_0.txt",
    parameter int WORD_ELEMS = 9,
    parameter int WORDS      = 4,
    parameter int PHASES     = 8,
    parameter int LAYERS     = 5,
    parameter int ADDR_W     = 8
) (
    input logic clk,
    input logic rst,
    weight_store_gen_if.slave bus
);
    localparam int WW = WORD_ELEMS * DATA_LEN;
    localparam int QW = WORDS * WW;
    localparam int CW = $clog2(WORDS + 2);
    wstore_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base;
    logic [CW-1:0]     cnt_q, cnt_d, idx_q, idx_d;
    logic              rd_q, rd_d, valid_q, valid_d, err_q, err_d, cs_ok;
    logic [QW-1:0]     q_q, q_d;
    logic [WW-1:0]     rom_q;
    w_rom_gen #(.FILENAME(FILENAME), .ADDR_W(ADDR_W), .WORD_ELEMS(WORD_ELEMS), .WW(WW)) u_rom (
        .clk (clk),
        .addr(addr_q),
        .q   (rom_q)
    );
    assign cs_ok = 32'(layer_idx(bus.cs)) < LAYERS;
    assign base  = ADDR_W'(layer_idx(bus.cs)) * ADDR_W'(PHASES * WORDS) + ADDR_W'(bus.phase) * ADDR_W'(WORDS);
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        unique case (state_q)
            WSTORE_IDLE: if (bus.load) begin
                addr_d  = cs_ok ? base : addr_q;
                cnt_d   = '0;
                err_d   = !cs_ok;
                state_d = cs_ok ? WSTORE_ISSUE : WSTORE_DONE;
            end
            WSTORE_ISSUE: if (!bus.load) state_d = WSTORE_IDLE;
            else begin
                addr_d  = cnt_q == CW'(WORDS - 1) ? addr_q : addr_q + 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(WORDS - 1) ? WSTORE_DRAIN : WSTORE_ISSUE;
            end
            WSTORE_DRAIN: if (!bus.load) state_d = WSTORE_IDLE;
            else if (cnt_q == CW'(WORDS + 1)) begin
                valid_d = 1'b1;
                state_d = WSTORE_DONE;
            end else cnt_d = cnt_q + 1'b1;
            WSTORE_DONE: if (!bus.load) begin
                valid_d = 1'b0;
                err_d   = 1'b0;
                state_d = WSTORE_IDLE;
            end
        endcase
    end
    // ROM data returns one cycle after issue; rd/idx track which slice it belongs to.
    assign rd_d  = state_q == WSTORE_ISSUE && bus.load;
    assign idx_d = cnt_q;
`ifdef WSTORE_DBUF_EN
    logic [QW-1:0] sh_q, sh_d;
    always_comb begin
        sh_d = sh_q;
        if (rd_q) sh_d[idx_q*WW +: WW] = rom_q;
    end
    assign q_d = valid_d && !valid_q ? sh_d : q_q;
    always_ff @(posedge clk) sh_q <= rst ? '0 : sh_d;
`else
    always_comb begin
        q_d = q_q;
        if (rd_q) q_d[idx_q*WW +: WW] = rom_q;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WSTORE_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            q_q     <= q_d;
        end
    end
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.q     = q_q;
    assign bus.addr  = addr_q;
endmodule

// File: tb/tb_weight_store_gen.sv
// tb_weight_store_gen: directed fetch sequences against hand-derived ROM contents and edge timing.
module tb_weight_store_gen;
    import weight_store_gen_pkg::*;
    localparam int WE = 9;
    localparam int WORDS = 4;
    localparam int WW = WE * 8;
    localparam int QW = WORDS * WW;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    weight_store_gen_if #(.WORD_ELEMS(WE), .WORDS(WORDS), .PHASES(8), .ADDR_W(8)) bus ();
    weight_store_gen #(.WORD_ELEMS(WE), .WORDS(WORDS), .PHASES(8), .LAYERS(5), .ADDR_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [WW-1:0] rom_word(input int a);
        logic [WW-1:0] w;
        for (int e = 0; e < WE; e++) begin
            int x;
            x = a * 3 + e * 17;
            w[e*8 +: 8] = 8'(x) ^ 8'h74;
        end
        return w;
    endfunction
    function automatic logic [QW-1:0] exp_vec(input int b);
        logic [QW-1:0] v;
        for (int k = 0; k < WORDS; k++) v[k*WW +: WW] = rom_word(b + k);
        return v;
    endfunction
    task automatic chk(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic fetch(input logic [3:0] c, input logic [2:0] p, input int b, input bit scramble);
        bus.cs = c;
        bus.phase = p;
        bus.load = 1'b1;
        step;
        chk("addr0", QW'(bus.addr), QW'(b));
        if (scramble) begin
            bus.cs = LAYER0;
            bus.phase = 3'd0;
        end
        for (int k = 1; k < WORDS; k++) begin
            step;
            chk("addr_k", QW'(bus.addr), QW'(b + k));
            chk("valid_early", QW'(bus.valid), QW'(0));
        end
        step;
        step;
        chk("valid_edge5", QW'(bus.valid), QW'(0));
        step;
        chk("valid_edge6", QW'(bus.valid), QW'(1));
        chk("q", bus.q, exp_vec(b));
        chk("err_ok", QW'(bus.err), QW'(0));
    endtask
    task automatic release_load;
        bus.load = 1'b0;
        step;
        chk("valid_drop", QW'(bus.valid), QW'(0));
    endtask
    initial begin
        bus.load = 1'b0;
        bus.cs = 4'd0;
        bus.phase = 3'd0;
        step;
        step;
        chk("rst_valid", QW'(bus.valid), QW'(0));
        chk("rst_err", QW'(bus.err), QW'(0));
        chk("rst_q", bus.q, QW'(0));
        chk("rst_addr", QW'(bus.addr), QW'(0));
        rst = 1'b0;
        fetch(LAYER1, 3'd2, 40, 1'b0);
        release_load;
        fetch(AFFINE, 3'd7, 156, 1'b0);
        chk("affine_last", QW'(bus.q[3*WW +: WW]), QW'(rom_word(159)));
        release_load;
        bus.cs = 4'hF;
        bus.load = 1'b1;
        step;
        chk("ill_err", QW'(bus.err), QW'(1));
        chk("ill_valid", QW'(bus.valid), QW'(0));
        chk("ill_addr", QW'(bus.addr), QW'(159));
        step;
        chk("ill_err_hold", QW'(bus.err), QW'(1));
        chk("ill_addr_hold", QW'(bus.addr), QW'(159));
        bus.load = 1'b0;
        step;
        chk("ill_err_clr", QW'(bus.err), QW'(0));
        bus.cs = LAYER1;
        bus.phase = 3'd2;
        bus.load = 1'b1;
        step;
        step;
        bus.load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step;
            chk("abort_valid", QW'(bus.valid), QW'(0));
        end
`ifdef WSTORE_DBUF_EN
        chk("abort_q_kept", bus.q, exp_vec(156));
`endif
        fetch(LAYER1, 3'd0, 32, 1'b0);
        release_load;
        bus.cs = LAYER2;
        bus.phase = 3'd1;
        bus.load = 1'b1;
        step;
        step;
        step;
        chk("pre_rst_addr", QW'(bus.addr), QW'(70));
        rst = 1'b1;
        step;
        chk("midrst_valid", QW'(bus.valid), QW'(0));
        chk("midrst_q", bus.q, QW'(0));
        chk("midrst_addr", QW'(bus.addr), QW'(0));
        rst = 1'b0;
        fetch(LAYER2, 3'd1, 68, 1'b0);
        release_load;
        fetch(LAYER3, 3'd5, 116, 1'b1);
        release_load;
        fetch(LAYER0, 3'd3, 12, 1'b0);
        release_load;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
